shift_reg_universal_n: RTL and testbench
========================================

# shift_reg_universal_n

Parametrised universal shift register with parallel load, bidirectional shift, rotate and arithmetic modes, plus a burst engine that performs N single-bit steps from one start command. It is the general-width successor to the 4-bit shift/load register and sits between switch/serial inputs and LED or downstream serial logic. It is usable as a serializer or deserializer of any width.

## Interface
- WIDTH, 8, register width in bits; minimum 2.
- CW (localparam), $clog2(WIDTH)+1, width of `amount`.
- clock  in  1  rising-edge clock.
- resetp  in  1  asynchronous, active-high reset.
- enable  in  1  single-step strobe; executes `mode` once per edge while idle.
- mode  in  3  operation select (see Operation).
- w_lsb  in  1  serial input shifted into q[0] on shift left.
- w_msb  in  1  serial input shifted into q[WIDTH-1] on shift right.
- d  in  WIDTH  parallel load data.
- start  in  1  burst request; sampled only when idle.
- amount  in  CW  burst step count N.
- q  out  WIDTH  register contents.
- so_msb  out  1  combinational q[WIDTH-1].
- so_lsb  out  1  combinational q[0].
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last burst step.

## Operation
- mode encodings:
  - 000: hold.
  - 001: shift left, q <= {q[WIDTH-2:0], w_lsb}.
  - 010: shift right, q <= {w_msb, q[WIDTH-1:1]}.
  - 011: rotate left.
  - 100: rotate right.
  - 101: arithmetic shift right; MSB replicated.
  - 110: parallel load, q <= d.
  - 111: synchronous clear, q <= 0.
- Reset: while resetp=1, q=0, busy=0, done=0, and the FSM is IDLE. Reset acts without a clock edge and overrides everything.
- FSM has two states, IDLE and RUN, with a down-counter `remaining` of CW bits.
- IDLE, start=1, amount≥1: latch mode into `bmode`, load remaining=amount, go to RUN. q is unchanged at this edge. start takes precedence over enable.
- IDLE, start=1, amount=0: q unchanged, stay IDLE, done=1 the next cycle, and busy is never asserted.
- Start with a latched mode of 000, 110 or 111 is legal. It is executed literally N times: hold does nothing, while load and clear are idempotent.
- IDLE, start=0, enable=1: execute `mode` once at this edge.
- IDLE, start=0, enable=0: hold.
- RUN: each edge executes `bmode` once and decrements remaining. When remaining goes 1→0, return to IDLE and assert done for one cycle.
- During RUN, `enable`, `mode`, `start`, `amount` and `d` are ignored; a new start is dropped, not queued. `w_lsb` and `w_msb` are sampled live at each step.
- Step counts ≥ WIDTH are executed literally. Shifts fill fully with serial input; rotates wrap modulo WIDTH.

## Timing
- Single-step operations take effect at the sampling edge, so q is valid the following cycle.
- Burst accepted at edge k with N≥1:
  - Steps occur at edges k+1 through k+N.
  - busy=1 for exactly N cycles, from after edge k until edge k+N.
  - done=1 for exactly the one cycle after edge k+N; busy=0 in that cycle.
  - A new start may be sampled at edge k+N+1, i.e. during the done cycle.
- Burst with N=0 at edge k: done=1 in the cycle after edge k, and q is unchanged.
- busy and done are registered. so_msb and so_lsb follow q combinationally.
- Reset mid-burst aborts immediately: q=0, busy=0, and no done pulse is issued. The first edge after release is treated as IDLE.

## Test plan
- Async reset: set q=0xFF, pulse resetp between edges -> q=0x00, busy=0 and done=0 before the next edge; outputs stay there while held.
- Single steps (WIDTH=8):
  - Load d=0xA5 -> q=0xA5.
  - mode 001 with w_lsb=1 -> q=0x4B.
  - mode 010 with w_msb=0 -> q=0x25.
  - mode 101 from 0x80 -> q=0xC0.
  - enable=0 with mode=001 -> q unchanged.
- Rotate-left burst from q=0x81, amount=3: q steps 0x03, 0x06, 0x0C on edges k+1..k+3 -> busy high for 3 cycles, then done high for 1 cycle with q=0x0C.
- Arithmetic-right burst from q=0x90, amount=2 -> q goes to 0xC8 then 0xE4. During the burst, toggling mode/enable and asserting start has no effect, and no second burst follows.
- amount=0 start -> done pulse next cycle, busy stays 0, q unchanged. Shift-left burst amount=10 with w_lsb=1 from 0x00 -> q=0xFF after 10 busy cycles.
- Reset mid-burst: amount=5 from 0x01 rotate left, resetp asserted after 2 steps (q=0x04) -> q=0, busy=0, no done. A following burst amount=1 from a loaded 0x01 -> q=0x02 and done asserts normally.

Source files
------------

// File: rtl/shift_reg_universal_n.sv
// shift_reg_universal_n: universal shift register with single-step and N-step burst execution
module shift_reg_universal_n #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             resetp,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic             w_lsb,
   input  logic             w_msb,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic [CW-1:0]    amount,
   output logic [WIDTH-1:0] q,
   output logic             so_msb,
   output logic             so_lsb,
   output logic             busy,
   output logic             done
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] bd_q, bd_d;
   logic [2:0]       bmode_q, bmode_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic             done_q, done_d;

   function automatic logic [WIDTH-1:0] step_f(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                               input logic wl, input logic wm,
                                               input logic [WIDTH-1:0] ld);
      case (m)
         3'b001:  step_f = {v[WIDTH-2:0], wl};
         3'b010:  step_f = {wm, v[WIDTH-1:1]};
         3'b011:  step_f = {v[WIDTH-2:0], v[WIDTH-1]};
         3'b100:  step_f = {v[0], v[WIDTH-1:1]};
         3'b101:  step_f = {v[WIDTH-1], v[WIDTH-1:1]};
         3'b110:  step_f = ld;
         3'b111:  step_f = '0;
         default: step_f = v;
      endcase
   endfunction

   // next state: burst start/steps take priority, otherwise a single enabled step
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      bd_d    = bd_q;
      bmode_d = bmode_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      if (state_q == RUN) begin
         q_d   = step_f(bmode_q, q_q, w_lsb, w_msb, bd_q);
         rem_d = rem_q - CW'(1);
         if (rem_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else if (start) begin
         if (amount == '0) begin
            done_d = 1'b1;
         end else begin
            state_d = RUN;
            bmode_d = mode;
            bd_d    = d;
            rem_d   = amount;
         end
      end else if (enable) begin
         q_d = step_f(mode, q_q, w_lsb, w_msb, d);
      end
   end

   // state registers; reset aborts any burst without a done pulse
   always_ff @(posedge clock or posedge resetp) begin
      if (resetp) begin
         state_q <= IDLE;
         q_q     <= '0;
         bd_q    <= '0;
         bmode_q <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         bd_q    <= bd_d;
         bmode_q <= bmode_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign q      = q_q;
   assign so_msb = q_q[WIDTH-1];
   assign so_lsb = q_q[0];
   assign busy   = (state_q == RUN);
   assign done   = done_q;
endmodule

// File: tb/tb_shift_reg_universal_n.sv
// tb_shift_reg_universal_n: scoreboard bench against a step-queue reference model
module tb_shift_reg_universal_n;
   localparam int W  = 8;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          resetp, enable, w_lsb, w_msb, start;
   logic [2:0]    mode;
   logic [W-1:0]  d, q;
   logic [CW-1:0] amount;
   logic          so_msb, so_lsb, busy, done;

   typedef struct {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t         exp_q[$];
   logic [2:0]   pend[$];
   logic [W-1:0] mq = '0;
   logic [W-1:0] bd = '0;
   int           n_checks = 0;
   int           n_fail = 0;

   shift_reg_universal_n #(.WIDTH(W)) dut (
      .clock(clock), .resetp(resetp), .enable(enable), .mode(mode),
      .w_lsb(w_lsb), .w_msb(w_msb), .d(d), .start(start), .amount(amount),
      .q(q), .so_msb(so_msb), .so_lsb(so_lsb), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [W-1:0] apply(input logic [2:0] m, input logic [W-1:0] v,
                                          input logic wl, input logic wm, input logic [W-1:0] ld);
      int unsigned x = v;
      case (m)
         3'd1: x = (x * 2 + int'(wl)) % 256;
         3'd2: x = x / 2 + int'(wm) * 128;
         3'd3: x = (x * 2) % 256 + x / 128;
         3'd4: x = x / 2 + (x % 2) * 128;
         3'd5: x = x / 2 + (x / 128) * 128;
         3'd6: x = ld;
         3'd7: x = 0;
         default: ;
      endcase
      return x[W-1:0];
   endfunction

   task automatic model_step();
      logic       md = 1'b0;
      logic [2:0] m;
      if (resetp) begin
         mq = '0;
         pend.delete();
      end else if (pend.size() > 0) begin
         m  = pend.pop_front();
         mq = apply(m, mq, w_lsb, w_msb, bd);
         md = (pend.size() == 0);
      end else if (start) begin
         if (amount == 0) md = 1'b1;
         else begin
            bd = d;
            repeat (amount) pend.push_back(mode);
         end
      end else if (enable) begin
         mq = apply(mode, mq, w_lsb, w_msb, d);
      end
      exp_q.push_back('{mq, pend.size() > 0, md});
   endtask

   task automatic drive(input logic st, input logic [CW-1:0] amt, input logic en, input logic [2:0] m,
                        input logic wl, input logic wm, input logic [W-1:0] dd);
      start = st; amount = amt; enable = en; mode = m; w_lsb = wl; w_msb = wm; d = dd;
      model_step();
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 3'd0, 0, 0, 8'h00);
   endtask

   task automatic load(input logic [W-1:0] v);
      drive(0, 0, 1, 3'd6, 0, 0, v);
   endtask

   task automatic async_reset();
      #2 resetp = 1'b1;
      #1;
      check("async_q", q, 0);
      check("async_busy", busy, 0);
      check("async_done", done, 0);
      idle(1);
      resetp = 1'b0;
   endtask

   // monitor: compare DUT against the oldest expectation just after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q", q, e.q);
            check("busy", busy, e.busy);
            check("done", done, e.done);
            check("so_msb", so_msb, e.q[W-1]);
            check("so_lsb", so_lsb, e.q[0]);
         end
      end
   end

   initial begin
      resetp = 1'b1;
      idle(2);
      resetp = 1'b0;
      load(8'hFF);
      async_reset();
      load(8'hA5);
      drive(0, 0, 1, 3'd1, 1, 0, 8'h00);
      drive(0, 0, 1, 3'd2, 0, 0, 8'h00);
      load(8'h80);
      drive(0, 0, 1, 3'd5, 0, 0, 8'h00);
      drive(0, 0, 0, 3'd1, 1, 1, 8'h00);
      load(8'h81);
      drive(1, 3, 0, 3'd3, 0, 0, 8'h00);
      idle(5);
      load(8'h90);
      drive(1, 2, 0, 3'd5, 0, 0, 8'h00);
      drive(1, 7, 1, 3'd6, 1, 1, 8'h3C);
      drive(0, 0, 1, 3'd7, 0, 0, 8'h00);
      idle(3);
      drive(1, 0, 1, 3'd1, 1, 1, 8'h00);
      idle(2);
      load(8'h00);
      drive(1, 10, 0, 3'd1, 1, 0, 8'h00);
      repeat (12) drive(0, 0, 0, 3'd0, 1, 0, 8'h00);
      load(8'h01);
      drive(1, 5, 0, 3'd3, 0, 0, 8'h00);
      idle(2);
      async_reset();
      idle(4);
      load(8'h01);
      drive(1, 1, 0, 3'd3, 0, 0, 8'h00);
      idle(3);
      repeat (400)
         drive($urandom_range(0, 7) == 0, CW'($urandom_range(0, 12)), 1'($urandom),
               3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      idle(16);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
